// File: rtl/reservoir_pkg.sv
// Shared definitions for the time-multiplexed reservoir: sequencer states,
// index-width helper and default sizing used by the node-register and readout blocks.
package reservoir_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int N_NODES_DEF = 16;
  localparam int MAC_LAT_DEF = 2;
  localparam int DATA_W      = 16;

  // Width of a node index; a single node still needs a 1-bit select.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder with enable; drives node-register write enables
// and the readout mux select.
module onehot_decoder #(
  parameter int N_OUT = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/reservoir_node_sequencer.sv
// Sequencer for the shared reservoir node datapath: accepts a sample, walks
// every virtual node for MAC_LAT cycles each, then offers the state vector.
module reservoir_node_sequencer
  import reservoir_pkg::*;
#(
  parameter int N_NODES = N_NODES_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = idx_w(N_NODES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               sample_en,
  output logic [IDX_W-1:0]   node_sel,
  output logic [N_NODES-1:0] node_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_cnt
);

  localparam int             LAT_W     = 4;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MAC_LAT - 1);
  localparam logic [IDX_W-1:0] NODE_LAST = IDX_W'(N_NODES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   node_sel_q, node_sel_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic               win_end;
  logic               node_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      node_sel_q   <= '0;
      lat_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      node_sel_q   <= node_sel_d;
      lat_cnt_q    <= lat_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign win_end = (lat_cnt_q == LAT_LAST);

  always_comb begin
    state_d      = state_q;
    node_sel_d   = node_sel_q;
    lat_cnt_d    = lat_cnt_q;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = COMPUTE;
          node_sel_d = '0;
          lat_cnt_d  = '0;
        end
      end
      COMPUTE: begin
        if (win_end) begin
          lat_cnt_d = '0;
          if (node_sel_q == NODE_LAST) begin
            state_d      = DONE;
            node_sel_d   = '0;
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end else begin
            node_sel_d = node_sel_q + IDX_W'(1);
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        node_sel_d = '0;
        lat_cnt_d  = '0;
      end
    endcase
  end

  // Reset leaves the state at IDLE, so in_ready is gated to stay low while held.
  assign in_ready   = rst_n && (state_q == IDLE);
  assign sample_en  = in_ready && in_valid;
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign node_sel   = node_sel_q;
  assign sample_cnt = sample_cnt_q;
  assign node_fire  = (state_q == COMPUTE) && win_end;

  onehot_decoder #(
    .N_OUT (N_NODES),
    .IDX_W (IDX_W)
  ) u_node_dec (
    .idx    (node_sel_q),
    .en     (node_fire),
    .onehot (node_en)
  );

endmodule

// File: tb/tb_reservoir_node_sequencer.sv
// Bench for reservoir_node_sequencer: three configurations driven side by side
// and compared every cycle against a schedule-based reference model.
module tb_reservoir_node_sequencer;
  import reservoir_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // a: N=4 L=2 W=16, b: N=1 L=1 W=16, c: N=4 L=2 W=2
  logic iv_a = 0, or_a = 0, ir_a, se_a, ov_a, bz_a;
  logic [1:0]  ns_a;
  logic [3:0]  ne_a;
  logic [15:0] sc_a;
  logic iv_b = 0, or_b = 0, ir_b, se_b, ov_b, bz_b;
  logic [0:0]  ns_b;
  logic [0:0]  ne_b;
  logic [15:0] sc_b;
  logic iv_c = 0, or_c = 0, ir_c, se_c, ov_c, bz_c;
  logic [1:0]  ns_c;
  logic [3:0]  ne_c;
  logic [1:0]  sc_c;

  reservoir_node_sequencer #(.N_NODES(4), .MAC_LAT(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .sample_en(se_a),
    .node_sel(ns_a), .node_en(ne_a), .out_valid(ov_a), .out_ready(or_a),
    .busy(bz_a), .sample_cnt(sc_a));
  reservoir_node_sequencer #(.N_NODES(1), .MAC_LAT(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .sample_en(se_b),
    .node_sel(ns_b), .node_en(ne_b), .out_valid(ov_b), .out_ready(or_b),
    .busy(bz_b), .sample_cnt(sc_b));
  reservoir_node_sequencer #(.N_NODES(4), .MAC_LAT(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .sample_en(se_c),
    .node_sel(ns_c), .node_en(ne_c), .out_valid(ov_c), .out_ready(or_c),
    .busy(bz_c), .sample_cnt(sc_c));

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting for sample, 1 = c-th compute cycle, 2 = offering result.
  localparam int NN [3] = '{4, 1, 4};
  localparam int ML [3] = '{2, 1, 2};
  localparam int CW [3] = '{16, 16, 2};
  int mode [3];
  int cyc  [3];
  int cnt  [3];

  int pulses_a = 0, pulses_b = 0;
  int last_c = 0;
  int seq_c [$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0; cyc[i] = 0; cnt[i] = 0;
    end
  endtask

  task automatic model_update(input int id, input logic iv, input logic ordy);
    if (!rst_n) begin
      mode[id] = 0; cyc[id] = 0; cnt[id] = 0;
    end else if (mode[id] == 0) begin
      if (iv) begin mode[id] = 1; cyc[id] = 0; end
    end else if (mode[id] == 1) begin
      cyc[id]++;
      if (cyc[id] == NN[id] * ML[id]) begin
        mode[id] = 2;
        cnt[id] = (cnt[id] + 1) % (1 << CW[id]);
      end
    end else if (ordy) begin
      mode[id] = 0;
    end
  endtask

  task automatic check_dut(input int id, input string p, input logic iv,
                           input logic ir, input logic se, input logic [31:0] ns,
                           input logic [31:0] ne, input logic ov, input logic bz,
                           input logic [31:0] sc);
    logic [31:0] e_ns, e_ne;
    logic e_ir;
    e_ir = rst_n && (mode[id] == 0);
    e_ns = (mode[id] == 1) ? 32'(cyc[id] / ML[id]) : 32'd0;
    e_ne = (mode[id] == 1 && (cyc[id] % ML[id]) == ML[id] - 1) ? (32'd1 << (cyc[id] / ML[id])) : 32'd0;
    check_eq({p, ".in_ready"},  32'(ir), 32'(e_ir));
    check_eq({p, ".sample_en"}, 32'(se), 32'(e_ir && iv));
    check_eq({p, ".node_sel"},  ns, e_ns);
    check_eq({p, ".node_en"},   ne, e_ne);
    check_eq({p, ".out_valid"}, 32'(ov), 32'(mode[id] == 2));
    check_eq({p, ".busy"},      32'(bz), 32'(mode[id] != 0));
    check_eq({p, ".sample_cnt"}, sc, 32'(cnt[id]));
  endtask

  task automatic compare_all();
    check_dut(0, "a", iv_a, ir_a, se_a, 32'(ns_a), 32'(ne_a), ov_a, bz_a, 32'(sc_a));
    check_dut(1, "b", iv_b, ir_b, se_b, 32'(ns_b), 32'(ne_b), ov_b, bz_b, 32'(sc_b));
    check_dut(2, "c", iv_c, ir_c, se_c, 32'(ns_c), 32'(ne_c), ov_c, bz_c, 32'(sc_c));
    if (ne_a != 0) pulses_a++;
    if (ne_b != 0) pulses_b++;
    if (32'(sc_c) != last_c) begin
      seq_c.push_back(int'(sc_c));
      last_c = int'(sc_c);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_update(0, iv_a, or_a);
    model_update(1, iv_b, or_b);
    model_update(2, iv_c, or_c);
    @(negedge clk);
  endtask

  task automatic set_all(input logic iv, input logic ordy);
    iv_a = iv; iv_b = iv; iv_c = iv;
    or_a = ordy; or_b = ordy; or_c = ordy;
  endtask

  initial begin
    int k;
    model_reset();
    set_all(1'b1, 1'b1);
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    seq_c.delete();
    last_c = 0;
    pulses_a = 0;
    pulses_b = 0;

    // Back-to-back: three full samples on a take exactly 30 cycles.
    for (int i = 0; i < 30; i++) step();
    check_eq("b2b.pulses_a", 32'(pulses_a), 32'd12);
    check_eq("b2b.cnt_a", 32'(sc_a), 32'd3);
    for (int i = 0; i < 20; i++) step();
    check_eq("b2b.pulses_b", 32'(pulses_b), 32'd17);
    check_eq("wrap.len_c", 32'(seq_c.size() >= 5), 32'd1);
    if (seq_c.size() >= 5) begin
      int exp_seq [5] = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) check_eq($sformatf("wrap.seq_c[%0d]", i), 32'(seq_c[i]), 32'(exp_seq[i]));
    end

    // Backpressure on a: hold out_ready low in DONE with a sample waiting.
    iv_a = 1'b1; or_a = 1'b0;
    k = 0;
    while (mode[0] != 2 && k < 20) begin step(); k++; end
    check_eq("bp.reach_done", 32'(mode[0] == 2), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check_eq("bp.out_valid", 32'(ov_a), 32'd1);
    check_eq("bp.in_ready", 32'(ir_a), 32'd0);
    or_a = 1'b1;
    step();
    step();

    // Randomized traffic on all three configurations.
    for (int i = 0; i < 3000; i++) begin
      iv_a = ($urandom_range(0, 3) != 0); or_a = ($urandom_range(0, 2) != 0);
      iv_b = ($urandom_range(0, 1) != 0); or_b = ($urandom_range(0, 3) != 0);
      iv_c = ($urandom_range(0, 4) != 0); or_c = ($urandom_range(0, 1) != 0);
      step();
    end

    // Reset in the middle of node 2 on a.
    set_all(1'b0, 1'b1);
    k = 0;
    while (mode[0] != 0 && k < 20) begin step(); k++; end
    iv_a = 1'b1;
    k = 0;
    while (!(mode[0] == 1 && cyc[0] / 2 == 2) && k < 20) begin step(); k++; end
    check_eq("rst.reach_node2", 32'(mode[0] == 1 && cyc[0] / 2 == 2), 32'd1);
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    iv_a = 1'b0;
    step();
    check_eq("rst.in_ready", 32'(ir_a), 32'd1);
    check_eq("rst.cnt", 32'(sc_a), 32'd0);

    // Illegal state encoding on a while everything is idle.
    set_all(1'b0, 1'b1);
    k = 0;
    while ((mode[0] | mode[1] | mode[2]) != 0 && k < 20) begin step(); k++; end
    force dut_a.state_q = state_e'(2'd3);
    #1;
    check_eq("ill.node_en", 32'(ne_a), 32'd0);
    release dut_a.state_q;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("ill.busy", 32'(bz_a), 32'd0);
    check_eq("ill.node_en_after", 32'(ne_a), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
